// File: rtl/switch_pulse_shaper.sv
// Per-channel switch conditioner: synchronise, detect rising edge, emit a bounded
// pulse, then hold off before re-arming. Channels share only clock, reset and stretch.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | armed, waiting for a synchronised rising edge
// ST_PULSE   | pulse active; counter runs up to PULSE_CNT-1 (saturates in stretch)
// ST_HOLDOFF | pulse finished; counter runs up to HOLDOFF_CNT-1 before re-arming
module switch_pulse_shaper #(
   parameter int CHANNELS    = 2,
   parameter int PULSE_CNT   = 600000,
   parameter int HOLDOFF_CNT = 60000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [CHANNELS-1:0] sw_in,
   input  logic [CHANNELS-1:0] inhibit,
   input  logic [CHANNELS-1:0] abort,
   input  logic                stretch,
   output logic [CHANNELS-1:0] pulse_out,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] dropped
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam int CNT_MAX = (PULSE_CNT > HOLDOFF_CNT) ? PULSE_CNT : HOLDOFF_CNT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CNT - 1);
   localparam logic [CW-1:0] HOLD_LAST  = (HOLDOFF_CNT > 0) ? CW'(HOLDOFF_CNT - 1) : '0;
   localparam state_t        END_STATE  = (HOLDOFF_CNT > 0) ? ST_HOLDOFF : ST_IDLE;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_s_q;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [CW-1:0]          r_cnt;
      logic [CW-1:0]          w_cnt_nxt;
      logic                   w_s;
      logic                   w_rise;
      logic                   w_drop;
      logic                   r_drop_d;
      logic                   r_pulse;
      logic                   r_busy;
      logic                   r_dropped;

      // Synchroniser and edge register reset high so a switch held through reset is not a press.
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            r_sync <= '1;
            r_s_q  <= 1'b1;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in[g]};
            r_s_q  <= w_s;
         end
      end

      assign w_s    = r_sync[SYNC_STAGES-1];
      assign w_rise = w_s & ~r_s_q;

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_drop      = 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  if (inhibit[g]) begin
                     w_drop = 1'b1;
                  end else begin
                     w_state_nxt = ST_PULSE;
                     w_cnt_nxt   = '0;
                  end
               end
            end
            ST_PULSE: begin
               w_drop = w_rise;
               if (abort[g] || ((r_cnt == PULSE_LAST) && (!stretch || !w_s))) begin
                  w_state_nxt = END_STATE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt != PULSE_LAST) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               w_drop = w_rise;
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Outputs trail the state by one register; the drop strobe is delayed to stay aligned.
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_drop_d  <= 1'b0;
            r_dropped <= 1'b0;
         end else begin
            r_pulse   <= (r_state == ST_PULSE);
            r_busy    <= (r_state != ST_IDLE);
            r_drop_d  <= w_drop;
            r_dropped <= r_drop_d;
         end
      end

      assign pulse_out[g] = r_pulse;
      assign busy[g]      = r_busy;
      assign dropped[g]   = r_dropped;
   end

endmodule

// File: doc/switch_pulse_shaper.md
# switch_pulse_shaper

Multi-channel switch conditioner that converts raw, asynchronous operator switch levels (coin, start, service) into clean fixed- or minimum-width pulses for discrete-logic game cores. Each channel synchronises its input, detects rising edges, emits a bounded pulse, then enforces a hold-off before re-arming. A per-channel inhibit suppresses new pulses, for example while credit is present. It sits between the input decoder and the core, replacing ad-hoc per-game coin pulse counters.

## Interface

Parameters:

- CHANNELS, default 2: number of independent channels.
- PULSE_CNT, default 600000: pulse length in clk_sys cycles; must be ≥ 1.
- HOLDOFF_CNT, default 60000: re-arm gap in clk_sys cycles; 0 disables hold-off.
- SYNC_STAGES, default 2: synchroniser depth; must be ≥ 2.

Ports:

- clk_sys  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- sw_in  in  CHANNELS  raw switch levels, asynchronous to clk_sys, active-high.
- inhibit  in  CHANNELS  synchronous to clk_sys; when high, rising edges on that channel are refused.
- abort  in  CHANNELS  synchronous; forces the channel's PULSE state to end immediately.
- stretch  in  1  synchronous mode select. 0: fixed-width pulse. 1: pulse lasts PULSE_CNT cycles minimum and extends while the switch is held.
- pulse_out  out  CHANNELS  conditioned pulse, registered.
- busy  out  CHANNELS  high whenever the channel is not IDLE.
- dropped  out  CHANNELS  one-cycle strobe when a rising edge is refused.

## Operation

- Per channel, sw_in passes through SYNC_STAGES flops to give `s`. A further register gives `s_q`. A rising edge is rise = s & ~s_q.
- On reset, all synchroniser flops and `s_q` load 1. An input held high through reset release therefore produces no pulse; a fresh press is required.
- Each channel has a counter of width $clog2(max(PULSE_CNT, HOLDOFF_CNT)+1). The FSM states are IDLE, PULSE and HOLDOFF.
- IDLE:
  - rise & ~inhibit: go to PULSE and clear the counter.
  - rise & inhibit: pulse dropped; stay in IDLE.
- PULSE: the counter increments every cycle.
  - abort has top priority: go to HOLDOFF (or IDLE if HOLDOFF_CNT = 0) and clear the counter.
  - When counter = PULSE_CNT-1 and (stretch = 0 or s = 0): go to HOLDOFF (or IDLE if HOLDOFF_CNT = 0) and clear the counter.
  - When counter = PULSE_CNT-1 and stretch = 1 and s = 1: the counter saturates and the state stays PULSE.
  - inhibit asserted mid-pulse does not truncate the pulse.
- HOLDOFF: the counter increments; at HOLDOFF_CNT-1 the channel goes to IDLE.
- Any rise in PULSE or HOLDOFF pulses dropped and is otherwise ignored. Edges are never queued.
- abort is ignored in IDLE and HOLDOFF.
- pulse_out = (state == PULSE). busy = (state != IDLE). Both are registered.
- Channels are fully independent. Simultaneous edges on several channels are each handled in the same cycle.
- stretch is sampled every cycle. Changing it mid-pulse affects only the end-of-pulse decision.

## Timing

- Reset values: pulse_out = 0, busy = 0, dropped = 0, all FSMs in IDLE, counters at 0.
- Reset assertion mid-pulse drops pulse_out asynchronously.
- Latency: sw_in is first sampled high at edge 0. pulse_out and busy rise after edge SYNC_STAGES+1.
- A dropped strobe occurs at the same edge offset and lasts exactly one cycle.
- Fixed mode: pulse_out is high for exactly PULSE_CNT cycles. busy is then high for HOLDOFF_CNT further cycles.
- Minimum re-arm spacing is PULSE_CNT+HOLDOFF_CNT cycles from pulse start. A rise detected in the first IDLE cycle is accepted.
- Stretch mode: pulse_out falls one cycle after `s` is seen low, provided counter = PULSE_CNT-1.
- abort: pulse_out falls on the edge after abort is sampled high.

## Test plan

All scenarios use PULSE_CNT = 8, HOLDOFF_CNT = 4, SYNC_STAGES = 2, CHANNELS = 2.

1. Press ch0 for 20 cycles with stretch = 0 → pulse_out[0] rises at edge 3, stays high 8 cycles, busy[0] high 12 cycles, no dropped.
2. Hold sw_in[0] = 1 across reset release → no pulse and busy stays 0. Release then press again → normal 8-cycle pulse.
3. Press ch1 with inhibit[1] = 1 → dropped[1] one-cycle strobe at edge 3, pulse_out[1] stays 0. Assert inhibit mid-pulse on ch0 → pulse still 8 cycles.
4. stretch = 1, hold ch0 for 30 cycles → pulse_out[0] high from edge 3 until one cycle after `s` falls. Release after 3 cycles → pulse still exactly 8 cycles.
5. Re-press ch0 during HOLDOFF → dropped[0] strobes and no second pulse. Press one cycle after busy falls → accepted.
6. Assert abort[0] at pulse cycle 3 → pulse_out[0] falls the next edge, followed by 4 HOLDOFF cycles. Ch1 runs a concurrent pulse unaffected.
